usb_rx_deframer: RTL and testbench

USB_RX_DEFRAMER -- requirements
Module: usb_rx_deframer

---
 rtl/usb_rx_pkg.sv | 13 +
 rtl/usb_bit_unstuff.sv | 67 ++++++
 rtl/usb_rx_deframer.sv | 123 ++++++++++++
 tb/tb_usb_rx_deframer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive deframer.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_DATA = 2'd2
    } rx_state_e;

    localparam int SYNC_MIN_DEFAULT = 12;
    localparam int STUFF_RUN        = 6;

endpackage

// File: rtl/usb_bit_unstuff.sv
// NRZI decoder and bit-stuff tracker: classifies each line bit as data,
// dropped stuff bit, or end-of-packet (stuff position holding a 1).
module usb_bit_unstuff
    import usb_rx_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    input  logic din_valid_i,
    input  logic active_i,
    input  logic data_mode_i,
    output logic bit_o,
    output logic bit_valid_o,
    output logic stuff_drop_o,
    output logic eop_o
);

    localparam logic [2:0] RUN = 3'(STUFF_RUN);

    logic       prev_q, prev_d;
    logic       primed_q, primed_d;
    logic [2:0] ones_q, ones_d;
    logic       dec;

    assign dec   = (din_i == prev_q);
    assign bit_o = dec;

    always_comb begin
        prev_d       = prev_q;
        primed_d     = primed_q;
        ones_d       = ones_q;
        bit_valid_o  = 1'b0;
        stuff_drop_o = 1'b0;
        eop_o        = 1'b0;
        if (!active_i) begin
            primed_d = 1'b0;
            ones_d   = 3'd0;
        end else if (din_valid_i) begin
            prev_d   = din_i;
            primed_d = 1'b1;
            // The first bit after leaving idle only seeds the line history.
            if (primed_q) begin
                if (data_mode_i && ones_q == RUN) begin
                    eop_o        = dec;
                    stuff_drop_o = !dec;
                    ones_d       = 3'd0;
                end else begin
                    bit_valid_o = 1'b1;
                    if (data_mode_i) ones_d = dec ? ones_q + 3'd1 : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q   <= 1'b1;
            primed_q <= 1'b0;
            ones_q   <= 3'd0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            ones_q   <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_deframer.sv
// USB receive deframer: SYNC hunt, byte assembly and EOP/abort handling
// on top of the NRZI/unstuff front end.
module usb_rx_deframer
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN = SYNC_MIN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       line_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error
);

    rx_state_e  state_q, state_d;
    logic [4:0] zcnt_q, zcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_error_q, rx_error_d;
    logic       need_low_q, need_low_d;

    logic dec_bit, dec_valid, stuff_drop, eop;

    usb_bit_unstuff u_unstuff (
        .clock        (clock),
        .reset        (reset),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .active_i     (state_q != ST_IDLE),
        .data_mode_i  (state_q == ST_DATA),
        .bit_o        (dec_bit),
        .bit_valid_o  (dec_valid),
        .stuff_drop_o (stuff_drop),
        .eop_o        (eop)
    );

    always_comb begin
        state_d    = state_q;
        zcnt_d     = zcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        need_low_d = need_low_q;
        // After an EOP the bus must be seen idle before hunting again.
        if (!line_active) need_low_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                zcnt_d = 5'd0;
                bcnt_d = 3'd0;
                if (line_active && !need_low_q) state_d = ST_HUNT;
            end
            ST_HUNT: begin
                if (!line_active) begin
                    state_d = ST_IDLE;
                end else if (dec_valid) begin
                    if (!dec_bit) begin
                        zcnt_d = (zcnt_q == 5'd31) ? zcnt_q : zcnt_q + 5'd1;
                    end else begin
                        zcnt_d = 5'd0;
                        if (int'(zcnt_q) >= SYNC_MIN) state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!line_active) begin
                    state_d    = ST_IDLE;
                    rx_error_d = 1'b1;
                    bcnt_d     = 3'd0;
                end else if (eop) begin
                    // Seven pending bits are the 0111111 head of a clean EOP.
                    state_d    = ST_IDLE;
                    need_low_d = 1'b1;
                    rx_error_d = (bcnt_q != 3'd7);
                    bcnt_d     = 3'd0;
                end else if (dec_valid && !stuff_drop) begin
                    shift_d = {dec_bit, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            zcnt_q     <= 5'd0;
            bcnt_q     <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            need_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            zcnt_q     <= zcnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_error_q <= rx_error_d;
            need_low_q <= need_low_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_error  = rx_error_q;
    assign rx_active = (state_q == ST_DATA);

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Directed scoreboard bench for usb_rx_deframer; line bits are NRZI-encoded
// from hand-written decoded bit vectors, expected bytes/errors queued ahead.
module tb_usb_rx_deframer;

    logic       clock;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       line_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    usb_rx_deframer #(.SYNC_MIN(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .line_active (line_active),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_active   (rx_active),
        .rx_error    (rx_error)
    );

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   act_rise = 0;
    int   act_fall = 0;
    logic act_prev = 1'b0;
    logic line = 1'b1;
    logic gaps = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every rx_valid / rx_error pulse is matched against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                act_prev = 1'b0;
            end else begin
                if (rx_active && !act_prev) act_rise++;
                if (!rx_active && act_prev) act_fall++;
                act_prev = rx_active;
                if (rx_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_byte: got rx_data=%h, expected no output", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.err || rx_data !== e.data) begin
                            n_bad++;
                            $display("FAIL byte: got byte %h, expected err=%0b data=%h", rx_data, e.err, e.data);
                        end
                    end
                end
                if (rx_error) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_error: got rx_error, expected no output");
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.err) begin
                            n_bad++;
                            $display("FAIL error: got rx_error, expected byte %h", e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic err, input logic [7:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_line(input logic l);
        if (gaps && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) begin
                din_valid = 1'b0;
                din       = 1'($urandom);
                tick();
            end
        end
        din       = l;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_dec(input logic b);
        line = b ? line : ~line;
        send_line(line);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_dec(v[i]);
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) send_dec(1'b0);
        send_dec(1'b1);
    endtask

    // Bus idle for two cycles, then active; first line bit seeds the decoder.
    task automatic start_session();
        line_active = 1'b0;
        tick();
        tick();
        line_active = 1'b1;
        tick();
        send_line(line);
    endtask

    task automatic settle();
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic packet_a5();
        int r0, f0;
        r0 = act_rise;
        f0 = act_fall;
        start_session();
        send_sync(31);
        chk("a5_active_after_sync", rx_active, 1);
        push(1'b0, 8'hA5);
        send_bits(64'hA5, 8);
        send_bits(64'h7E, 7);   // 0 then six 1s: pending head of EOP
        chk("a5_active_before_eop", rx_active, 1);
        send_dec(1'b1);
        chk("a5_active_after_eop", rx_active, 0);
        settle();
        chk("a5_one_rise", act_rise - r0, 1);
        chk("a5_one_fall", act_fall - f0, 1);
    endtask

    initial begin
        int r0;
        reset       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        line_active = 1'b0;
        repeat (3) tick();
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_active", rx_active, 0);
        chk("reset_rx_error", rx_error, 0);
        reset = 1'b1;
        tick();

        // Basic packet: 31-zero SYNC, byte A5, clean EOP.
        packet_a5();

        // After EOP with the bus still active, a fresh SYNC must be ignored.
        r0 = act_rise;
        send_sync(12);
        tick();
        chk("no_rehunt_without_idle", act_rise - r0, 0);

        // Short SYNCs (10 and 11 zeros) rejected, exactly 12 accepted.
        r0 = act_rise;
        start_session();
        send_sync(10);
        chk("sync10_rejected", rx_active, 0);
        send_sync(11);
        chk("sync11_rejected", rx_active, 0);
        chk("short_sync_no_rise", act_rise - r0, 0);
        send_sync(12);
        chk("sync12_accepted", rx_active, 1);
        // FF with stuffed 0 after six 1s, then 00, then clean EOP.
        push(1'b0, 8'hFF);
        push(1'b0, 8'h00);
        send_bits(64'h1BF, 9);
        send_bits(64'h00, 8);
        send_bits(64'hFE, 8);
        chk("stuff_active_after_eop", rx_active, 0);
        settle();

        // Data 1,1,1 then 1s: stuff slot hits with 6 bits pending -> error.
        r0 = act_fall;
        start_session();
        send_sync(12);
        push(1'b1, 8'h00);
        send_bits(64'h7, 3);
        send_bits(64'h7F, 7);
        chk("bad_eop_active_low", rx_active, 0);
        settle();
        chk("bad_eop_fall", act_fall - r0, 1);

        // Bus drops after 12 data bits: byte 3C delivered, then error.
        start_session();
        send_sync(12);
        push(1'b0, 8'h3C);
        push(1'b1, 8'h00);
        send_bits(64'h3C, 8);
        send_bits(64'hA, 4);
        line_active = 1'b0;
        tick();
        chk("drop_active_low", rx_active, 0);
        settle();

        // Reset mid-packet aborts silently.
        start_session();
        send_sync(12);
        send_bits(64'h15, 5);
        reset = 1'b0;
        tick();
        chk("midreset_active", rx_active, 0);
        chk("midreset_error", rx_error, 0);
        tick();
        reset = 1'b1;
        settle();

        // Same A5 packet with random din_valid gaps.
        gaps = 1'b1;
        packet_a5();
        gaps = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
